mem_port_arbiter: RTL

Two-requester arbiter that shares the single memory port (enable, read/write, address, write data, MFC completion) between the instruction-fetch path (requester 0) and the load/store sequencer (requester 1). It sits between those controllers and the memory. It grants one requester at a time and drives the memory on the grantee's behalf. It holds the grant until MFC or a timeout, then returns read data with a one-cycle acknowledge.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/arb_rr2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, requester
// indices and default bus widths.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  // Requester indices; also the encoding of the grantee and last-served bits.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LS    = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker. On a tie the requester that was
// not served last wins; a lone requester always wins.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastServed,
  output logic       winner,
  output logic       valid
);

  // Pick the winner from the request vector and the last-served pointer.
  always_comb begin
    valid  = |req;
    winner = REQ_FETCH;
    if (req == 2'b11) begin
      winner = ~lastServed;
    end else if (req[REQ_LS]) begin
      winner = REQ_LS;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (requester 0) and the
// load/store sequencer (requester 1). The grantee's command is latched on
// entry to ACCESS and held until MFC or timeout, followed by a one-cycle ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mfc
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  state_t            stateQ, stateD;
  logic              grantQ, grantD;
  logic              lastQ, lastD;
  logic              rwQ, rwD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [DATA_W-1:0] wdataQ, wdataD;
  logic [CntW-1:0]   cntQ, cntD;
  logic              errQ, errD;
  logic [DATA_W-1:0] rdataQ, rdataD;

  logic pickWinner;
  logic pickValid;

  arb_rr2 uPicker (
    .req        ({req1, req0}),
    .lastServed (lastQ),
    .winner     (pickWinner),
    .valid      (pickValid)
  );

  // State and datapath registers; last-served starts at LS so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= IDLE;
      grantQ <= REQ_FETCH;
      lastQ  <= REQ_LS;
      rwQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      cntQ   <= '0;
      errQ   <= 1'b0;
      rdataQ <= '0;
    end else begin
      stateQ <= stateD;
      grantQ <= grantD;
      lastQ  <= lastD;
      rwQ    <= rwD;
      addrQ  <= addrD;
      wdataQ <= wdataD;
      cntQ   <= cntD;
      errQ   <= errD;
      rdataQ <= rdataD;
    end
  end

  // Next-state: arbitrate and latch in IDLE, wait for MFC or timeout in ACCESS.
  always_comb begin
    stateD = stateQ;
    grantD = grantQ;
    lastD  = lastQ;
    rwD    = rwQ;
    addrD  = addrQ;
    wdataD = wdataQ;
    cntD   = cntQ;
    errD   = errQ;
    rdataD = rdataQ;
    unique case (stateQ)
      IDLE: begin
        if (pickValid) begin
          stateD = ACCESS;
          grantD = pickWinner;
          lastD  = pickWinner;
          cntD   = '0;
          if (pickWinner == REQ_LS) begin
            rwD    = rw1;
            addrD  = addr1;
            wdataD = wdata1;
          end else begin
            rwD    = rw0;
            addrD  = addr0;
            wdataD = wdata0;
          end
        end
      end
      ACCESS: begin
        // MFC wins over a timeout landing in the same cycle.
        if (mfc) begin
          stateD = DONE;
          errD   = 1'b0;
          if (rwQ) begin
            rdataD = mem_rdata;
          end
        end else if (cntQ == CntMax) begin
          stateD = DONE;
          errD   = 1'b1;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      DONE: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // Outputs decoded from state and the latched grantee only.
  always_comb begin
    mem_en    = (stateQ == ACCESS);
    mem_rw    = rwQ;
    mem_addr  = addrQ;
    mem_wdata = wdataQ;
    gnt0      = (stateQ != IDLE) && (grantQ == REQ_FETCH);
    gnt1      = (stateQ != IDLE) && (grantQ == REQ_LS);
    ack0      = (stateQ == DONE) && (grantQ == REQ_FETCH);
    ack1      = (stateQ == DONE) && (grantQ == REQ_LS);
    err       = errQ;
    rdata     = rdataQ;
  end

endmodule
